// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the SRAM copy/fill initiator.
// Optional fill mode is enabled by defining MEM_COPY_INITIATOR_FILL_EN.
package mem_copy_pkg;

  localparam int          WORD_W = 32;
  localparam logic [3:0]  BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef MEM_COPY_INITIATOR_FILL_EN
    ST_FILL  = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_e;

endpackage

// File: rtl/mem_copy_range_check.sv
// Flags a block [base, base+len) that runs past the end of the memory.
module mem_copy_range_check #(
  parameter  int NumWords  = 1024,
  localparam int AddrWidth = (NumWords <= 1) ? 1 : $clog2(NumWords),
  localparam int LenWidth  = AddrWidth + 1
) (
  input  logic [AddrWidth-1:0] base_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 err_o
);

  // One extra bit over the length width so base+len can never wrap.
  logic [LenWidth:0] end_addr;

  assign end_addr = (LenWidth+1)'(base_i) + (LenWidth+1)'(len_i);
  assign err_o    = end_addr > (LenWidth+1)'(NumWords);

endmodule

// File: rtl/mem_copy_initiator.sv
// Autonomous word copy (and optional fill) engine on a single-port SRAM port.
// Define MEM_COPY_INITIATOR_FILL_EN to add fill mode and the FILL state.
module mem_copy_initiator
  import mem_copy_pkg::*;
#(
  parameter  int NumWords  = 1024,
  localparam int AddrWidth = (NumWords <= 1) ? 1 : $clog2(NumWords),
  localparam int LenWidth  = AddrWidth + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] src_i,
  input  logic [AddrWidth-1:0] dst_i,
  input  logic [LenWidth-1:0]  len_i,
  input  logic                 mode_i,
  input  logic [WORD_W-1:0]    pattern_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [WORD_W-1:0]    wdata_o,
  output logic [3:0]           be_o,
  input  logic [WORD_W-1:0]    rdata_i
);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_q, dst_q;
  logic [LenWidth-1:0]  cnt_q;
  logic                 err_q;
  logic                 src_err, dst_err, range_err;
  logic                 cmd_fill, len_zero, load, step, last;

`ifdef MEM_COPY_INITIATOR_FILL_EN
  logic [WORD_W-1:0]    pattern_q;

  assign cmd_fill = (mode_i == MODE_FILL);
  assign step     = (state_q == ST_WRITE) || (state_q == ST_FILL);
`else
  logic                 unused_cfg;

  assign unused_cfg = ^{mode_i, pattern_i};
  assign cmd_fill   = 1'b0;
  assign step       = (state_q == ST_WRITE);
`endif

  mem_copy_range_check #(.NumWords(NumWords)) u_src_check (
    .base_i (src_i),
    .len_i  (len_i),
    .err_o  (src_err)
  );

  mem_copy_range_check #(.NumWords(NumWords)) u_dst_check (
    .base_i (dst_i),
    .len_i  (len_i),
    .err_o  (dst_err)
  );

  // A fill never reads, so only the destination range matters for it.
  assign range_err = cmd_fill ? dst_err : (src_err | dst_err);
  assign len_zero  = (len_i == '0);
  assign load      = (state_q == ST_IDLE) && start_i;
  assign last      = (cnt_q == LenWidth'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= len_i;
        err_q <= range_err;
      end else if (step) begin
        cnt_q <= cnt_q - LenWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (load) begin
      src_q <= src_i;
      dst_q <= dst_i;
    end else if (step) begin
      src_q <= src_q + AddrWidth'(1);
      dst_q <= dst_q + AddrWidth'(1);
    end
  end

`ifdef MEM_COPY_INITIATOR_FILL_EN
  always_ff @(posedge clk_i) begin
    if (load) begin
      pattern_q <= pattern_i;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    err_o   = 1'b0;
    req_o   = 1'b0;
    we_o    = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    be_o    = 4'h0;
    unique case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          if (len_zero || range_err) begin
            state_d = ST_DONE;
          end
`ifdef MEM_COPY_INITIATOR_FILL_EN
          else if (cmd_fill) begin
            state_d = ST_FILL;
          end
`endif
          else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        // An abort here suppresses the read request in the same cycle.
        if (abort_i) begin
          state_d = ST_DONE;
        end else begin
          req_o   = 1'b1;
          addr_o  = src_q;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        addr_o  = dst_q;
        wdata_o = rdata_i;
        be_o    = BE_ALL;
        state_d = (abort_i || last) ? ST_DONE : ST_READ;
      end
`ifdef MEM_COPY_INITIATOR_FILL_EN
      ST_FILL: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        addr_o  = dst_q;
        wdata_o = pattern_q;
        be_o    = BE_ALL;
        state_d = (abort_i || last) ? ST_DONE : ST_FILL;
      end
`endif
      ST_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = ST_IDLE;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Directed bench for mem_copy_initiator with a behavioural single-port SRAM.
module tb_mem_copy_initiator;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [9:0]  src_i, dst_i;
  logic [10:0] len_i;
  logic        mode_i;
  logic [31:0] pattern_i;
  logic        abort_i;
  logic        busy_o, done_o, err_o, req_o, we_o;
  logic [9:0]  addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic [31:0] rdata_i;

  logic [31:0] mem [0:1023];
  logic        pl_we;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] av [0:3];
  logic [31:0] cv [0:3];
  localparam logic [31:0] SENT = 32'h5A5A_5A5A;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_copy_initiator #(.NumWords(1024)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .src_i     (src_i),
    .dst_i     (dst_i),
    .len_i     (len_i),
    .mode_i    (mode_i),
    .pattern_i (pattern_i),
    .abort_i   (abort_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .req_o     (req_o),
    .we_o      (we_o),
    .addr_o    (addr_o),
    .wdata_o   (wdata_o),
    .be_o      (be_o),
    .rdata_i   (rdata_i)
  );

  // SRAM model: byte-enabled write, registered read data.
  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (req_o) begin
      if (we_o) begin
        for (int b = 0; b < 4; b++)
          if (be_o[b]) mem[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
      end else begin
        rdata_i <= mem[addr_o];
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // Issues one command (start in cycle 0) and records per-cycle observations until done_o.
  task automatic run_cmd(input logic [9:0] src, input logic [9:0] dst, input logic [10:0] len,
                         input logic mode, input logic [31:0] pat, input int abort_cyc,
                         output int dc, output logic er, output int rc, output int wc,
                         output int fr, output int lr, output int ob);
    dc = -1; er = 1'b0; rc = 0; wc = 0; fr = -1; lr = -1; ob = 0;
    @(posedge clk); #1;
    src_i = src; dst_i = dst; len_i = len; mode_i = mode; pattern_i = pat;
    start_i = 1'b1; abort_i = (abort_cyc == 0);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (req_o) begin
        rc++;
        if (fr < 0) fr = c;
        lr = c;
        if (we_o) wc++;
      end
      if (we_o && (!req_o || be_o !== 4'hF)) ob++;
      if (!we_o && be_o !== 4'h0) ob++;
      if (!req_o && (addr_o !== '0 || wdata_o !== '0)) ob++;
      if (!done_o && err_o) ob++;
      if (done_o) begin
        dc = c; er = err_o;
        break;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      abort_i = (c + 1 == abort_cyc);
    end
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1; src_i = 10'd0; dst_i = 10'd5; len_i = 11'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy_o, done_o, err_o, req_o, we_o, be_o, addr_o, wdata_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%0b req=%0b we=%0b be=%h addr=%0d", busy_o, req_o, we_o, be_o, addr_o);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_busy: got %0b expected 0", busy_o); end
  endtask

  task automatic test_copy();
    int dc, rc, wc, fr, lr, ob; logic er;
    run_cmd(10'd0, 10'd100, 11'd4, 1'b0, 32'h0, -1, dc, er, rc, wc, fr, lr, ob);
    tests_run++; if (fr !== 1) begin tests_failed++; $display("FAIL copy_first_req: got %0d expected 1", fr); end
    tests_run++; if (dc !== 9) begin tests_failed++; $display("FAIL copy_done_cycle: got %0d expected 9", dc); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL copy_err: got %0b expected 0", er); end
    tests_run++; if (rc !== 8 || wc !== 4) begin tests_failed++; $display("FAIL copy_req_count: got %0d/%0d expected 8/4", rc, wc); end
    tests_run++; if (ob !== 0) begin tests_failed++; $display("FAIL copy_idle_outputs: got %0d bad cycles expected 0", ob); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL copy_back_idle: got busy=%0b expected 0", busy_o); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[100+i] !== av[i]) begin tests_failed++; $display("FAIL copy_data[%0d]: got %h expected %h", i, mem[100+i], av[i]); end
    end
    tests_run++; if (mem[104] !== SENT) begin tests_failed++; $display("FAIL copy_overrun: got %h expected %h", mem[104], SENT); end
    run_cmd(10'd1020, 10'd200, 11'd4, 1'b0, 32'h0, -1, dc, er, rc, wc, fr, lr, ob);
    tests_run++; if (dc !== 9 || er !== 1'b0) begin tests_failed++; $display("FAIL copy_top_edge: got done=%0d err=%0b expected 9/0", dc, er); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[200+i] !== cv[i]) begin tests_failed++; $display("FAIL copy_top_data[%0d]: got %h expected %h", i, mem[200+i], cv[i]); end
    end
  endtask

  task automatic test_range_err();
    int dc, rc, wc, fr, lr, ob; logic er;
    run_cmd(10'd1020, 10'd0, 11'd8, 1'b0, 32'h0, -1, dc, er, rc, wc, fr, lr, ob);
    tests_run++; if (dc !== 1 || er !== 1'b1) begin tests_failed++; $display("FAIL src_range: got done=%0d err=%0b expected 1/1", dc, er); end
    tests_run++; if (rc !== 0) begin tests_failed++; $display("FAIL src_range_req: got %0d expected 0", rc); end
    run_cmd(10'd0, 10'd1000, 11'd30, 1'b0, 32'h0, -1, dc, er, rc, wc, fr, lr, ob);
    tests_run++; if (dc !== 1 || er !== 1'b1 || rc !== 0) begin tests_failed++; $display("FAIL dst_range: got done=%0d err=%0b req=%0d expected 1/1/0", dc, er, rc); end
  endtask

  task automatic test_len_zero();
    int dc, rc, wc, fr, lr, ob; logic er;
    run_cmd(10'd5, 10'd6, 11'd0, 1'b0, 32'h0, -1, dc, er, rc, wc, fr, lr, ob);
    tests_run++; if (dc !== 1 || er !== 1'b0 || rc !== 0) begin tests_failed++; $display("FAIL len_zero: got done=%0d err=%0b req=%0d expected 1/0/0", dc, er, rc); end
  endtask

  task automatic test_fill();
    int dc, rc, wc, fr, lr, ob; logic er;
`ifdef MEM_COPY_INITIATOR_FILL_EN
    run_cmd(10'd0, 10'd10, 11'd3, 1'b1, 32'hDEAD_BEEF, -1, dc, er, rc, wc, fr, lr, ob);
    tests_run++; if (fr !== 1 || lr !== 3 || wc !== 3) begin tests_failed++; $display("FAIL fill_writes: got first=%0d last=%0d wr=%0d expected 1/3/3", fr, lr, wc); end
    tests_run++; if (dc !== 4 || er !== 1'b0) begin tests_failed++; $display("FAIL fill_done: got %0d/%0b expected 4/0", dc, er); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (mem[10+i] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL fill_data[%0d]: got %h expected deadbeef", i, mem[10+i]); end
    end
    tests_run++; if (mem[13] !== SENT) begin tests_failed++; $display("FAIL fill_overrun: got %h expected %h", mem[13], SENT); end
    run_cmd(10'd1023, 10'd20, 11'd3, 1'b1, 32'h1234_5678, -1, dc, er, rc, wc, fr, lr, ob);
    tests_run++; if (dc !== 4 || er !== 1'b0) begin tests_failed++; $display("FAIL fill_ignores_src: got %0d/%0b expected 4/0", dc, er); end
`else
    run_cmd(10'd0, 10'd20, 11'd2, 1'b1, 32'hDEAD_BEEF, -1, dc, er, rc, wc, fr, lr, ob);
    tests_run++; if (dc !== 5 || rc !== 4) begin tests_failed++; $display("FAIL mode_ignored: got done=%0d req=%0d expected 5/4", dc, rc); end
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (mem[20+i] !== av[i]) begin tests_failed++; $display("FAIL mode_ignored_data[%0d]: got %h expected %h", i, mem[20+i], av[i]); end
    end
`endif
  endtask

  task automatic test_abort();
    int dc, rc, wc, fr, lr, ob; logic er;
    run_cmd(10'd0, 10'd300, 11'd5, 1'b0, 32'h0, 4, dc, er, rc, wc, fr, lr, ob);
    tests_run++; if (dc !== 5 || er !== 1'b0) begin tests_failed++; $display("FAIL abort_write_done: got %0d/%0b expected 5/0", dc, er); end
    tests_run++; if (wc !== 2) begin tests_failed++; $display("FAIL abort_write_count: got %0d expected 2", wc); end
    tests_run++;
    if (mem[300] !== av[0] || mem[301] !== av[1] || mem[302] !== SENT) begin
      tests_failed++; $display("FAIL abort_write_data: got %h %h %h", mem[300], mem[301], mem[302]);
    end
    run_cmd(10'd0, 10'd310, 11'd5, 1'b0, 32'h0, 3, dc, er, rc, wc, fr, lr, ob);
    tests_run++; if (dc !== 4 || rc !== 2 || er !== 1'b0) begin tests_failed++; $display("FAIL abort_read: got done=%0d req=%0d err=%0b expected 4/2/0", dc, rc, er); end
  endtask

  task automatic test_back_to_back();
    int dc2;
    @(posedge clk); #1;
    src_i = 10'd0; dst_i = 10'd400; len_i = 11'd1; mode_i = 1'b0; start_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    tests_run++; if (done_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_done: got %0b expected 1", done_o); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_start_in_done: got busy=%0b expected 0", busy_o); end
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    tests_run++; if (req_o !== 1'b1 || we_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_restart: got req=%0b we=%0b expected 1/0", req_o, we_o); end
    dc2 = -1;
    for (int c = 6; c < 40; c++) begin
      @(negedge clk);
      if (done_o) begin dc2 = c; break; end
    end
    tests_run++; if (dc2 !== 7) begin tests_failed++; $display("FAIL b2b_second_done: got %0d expected 7", dc2); end
    tests_run++; if (mem[400] !== av[0]) begin tests_failed++; $display("FAIL b2b_data: got %h expected %h", mem[400], av[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int dc, rc, wc, fr, lr, ob; logic er;
    @(posedge clk); #1;
    src_i = 10'd0; dst_i = 10'd500; len_i = 11'd10; mode_i = 1'b0; start_i = 1'b1;
    repeat (5) begin @(posedge clk); #1; start_i = 1'b0; end
    tests_run++; if (req_o !== 1'b1 || we_o !== 1'b0 || addr_o !== 10'd2) begin tests_failed++; $display("FAIL mid_third_read: got req=%0b we=%0b addr=%0d expected 1/0/2", req_o, we_o, addr_o); end
    rst_i = 1'b1; #1;
    tests_run++;
    if ({busy_o, done_o, err_o, req_o, we_o, be_o, addr_o, wdata_o} !== '0) begin
      tests_failed++; $display("FAIL mid_reset_outputs: got busy=%0b req=%0b addr=%0d", busy_o, req_o, addr_o);
    end
    @(posedge clk); #1; @(posedge clk); #1;
    rst_i = 1'b0;
    tests_run++;
    if (mem[500] !== av[0] || mem[501] !== av[1] || mem[502] !== SENT) begin
      tests_failed++; $display("FAIL mid_partial_dst: got %h %h %h", mem[500], mem[501], mem[502]);
    end
    run_cmd(10'd0, 10'd600, 11'd2, 1'b0, 32'h0, -1, dc, er, rc, wc, fr, lr, ob);
    tests_run++; if (dc !== 5 || er !== 1'b0) begin tests_failed++; $display("FAIL mid_fresh_done: got %0d/%0b expected 5/0", dc, er); end
    tests_run++; if (mem[600] !== av[0] || mem[601] !== av[1]) begin tests_failed++; $display("FAIL mid_fresh_data: got %h %h", mem[600], mem[601]); end
  endtask

  initial begin
    av[0] = 32'hA0A0_0000; av[1] = 32'hA1A1_1111; av[2] = 32'hA2A2_2222; av[3] = 32'hA3A3_3333;
    cv[0] = 32'hC0C0_0C0C; cv[1] = 32'hC1C1_1C1C; cv[2] = 32'hC2C2_2C2C; cv[3] = 32'hC3C3_3C3C;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0; pattern_i = '0;
    src_i = '0; dst_i = '0; len_i = '0;
    test_reset();
    for (int i = 0; i < 4; i++) preload(10'(i), av[i]);
    for (int i = 0; i < 4; i++) preload(10'(1020 + i), cv[i]);
    preload(10'd104, SENT);
    preload(10'd13, SENT);
    preload(10'd302, SENT);
    preload(10'd502, SENT);
    test_copy();
    test_range_err();
    test_len_zero();
    test_fill();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_copy_initiator.md
# mem_copy_initiator

Initiator for the single-port SRAM interface (req/we/addr/wdata/be in, rdata one cycle later): accepts a copy command (source word address, destination word address, length) and autonomously moves words within one memory instance. It sits beside the memory wrapper in the simulation and accelerator subsystem, muxed onto the SRAM port. Software and the testbench use it for bulk initialisation and buffer moves.

## Interface
- NumWords, 1024: words in the target memory.
- AddrWidth, $clog2(NumWords) (1 if NumWords≤1): derived, never overridden.
- LenWidth, AddrWidth+1: derived; length up to NumWords.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  command strobe; sampled only in IDLE.
- src_i  in  AddrWidth  source word address.
- dst_i  in  AddrWidth  destination word address.
- len_i  in  LenWidth  word count.
- mode_i  in  1  0 = copy, 1 = fill. Only meaningful with the fill macro.
- pattern_i  in  32  fill word.
- abort_i  in  1  stop the current command early.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  range error, valid with done_o.
- req_o, we_o  out  1 each  SRAM request and write enable.
- addr_o  out  AddrWidth  SRAM word address.
- wdata_o  out  32  SRAM write data.
- be_o  out  4  byte enables; always 4'hF when we_o is high, 4'h0 otherwise.
- rdata_i  in  32  SRAM read data, valid the cycle after a read request.

## Operation
- States:
  - IDLE: waits for a command.
  - READ: req_o=1, we_o=0, addr_o=src pointer.
  - WRITE: req_o=1, we_o=1, addr_o=dst pointer, wdata_o=rdata_i (combinational pass-through).
  - FILL: req_o=1, we_o=1, wdata_o=pattern latched at start.
  - DONE: done_o=1 for one cycle.
- IDLE with start_i: latch src, dst, len, mode and pattern.
  - len==0, or range error: go to DONE.
  - Otherwise go to READ (copy) or FILL (fill).
- Range error: src+len > NumWords (copy only) or dst+len > NumWords. Compute with LenWidth+1-bit arithmetic so the sum cannot overflow. On error, err_o=1 in DONE and no SRAM access is issued.
- Copy: READ→WRITE→READ…; after each WRITE, increment both pointers and decrement the remaining count. Count reaching 0 after a WRITE goes to DONE.
- Fill: one write per cycle in FILL; count reaching 0 goes to DONE.
- Overlapping regions: strict ascending word order. No memmove semantics.
- abort_i:
  - In READ: go to DONE without issuing a request.
  - In WRITE or FILL: complete the current write, then go to DONE.
  - err_o is not set by an abort.
- start_i outside IDLE is ignored, including in the DONE cycle.
- DONE goes to IDLE unconditionally.
- busy_o=1 in READ, WRITE, FILL and DONE.
- Outputs are 0 in IDLE and DONE: req_o, we_o, addr_o, wdata_o, be_o.

## Timing
- Reset: state=IDLE. All outputs 0 on reset and while in reset: busy_o, done_o, err_o, req_o, we_o, addr_o, wdata_o, be_o.
- Reset asserted mid-command returns to IDLE immediately, with no done_o. A partially written destination is left as is.
- start_i seen in cycle 0 → first request in cycle 1.
- Copy of N words: requests in cycles 1..2N; done_o in cycle 2N+1; IDLE in cycle 2N+2.
- Fill of N words: writes in cycles 1..N; done_o in cycle N+1.
- len==0 or range error: done_o in cycle 1, with no requests.
- A new command is accepted one cycle after DONE at the earliest.

## Configuration
- MEM_COPY_INITIATOR_FILL_EN defined: fill mode and the FILL state are present.
- Macro undefined:
  - mode_i and pattern_i remain ports but are ignored.
  - Every command is a copy.
  - The FILL state does not exist.

## Structure
- mem_copy_pkg holds:
  - the state enum (IDLE, READ, WRITE, FILL, DONE);
  - the mode enum;
  - the byte-enable constant BE_ALL = 4'hF.
- One sub-module, mem_copy_range_check: combinational; takes base and len and produces the error flag. It is instantiated twice, for src and dst.

## Test plan
- Preload words 0..3 = A0..A3; copy src=0, dst=100, len=4 → words 100..103 = A0..A3; done_o in cycle 9; err_o=0.
- Copy src=1020, dst=0, len=8 (NumWords=1024) → done_o in cycle 1, err_o=1, no req_o.
- len=0 → done_o in cycle 1, err_o=0, no req_o.
- Fill (macro on), dst=10, len=3, pattern=32'hDEADBEEF → writes in cycles 1..3, done_o in cycle 4.
- Copy len=5 with abort_i in the 2nd WRITE cycle → exactly 2 words written, done_o the next cycle.
- Assert rst_i during the 3rd READ of a len=10 copy → all outputs 0 immediately; a fresh command afterwards completes normally.
